// File: rtl/rf_pkg.sv
// Shared constants and types for the integer register file and its scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_pkg;
  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [4:0] reg_addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for long-latency destinations, with a pending count and a conflict flag.
// Latency: busy and count update on the edge; BUSY_OUT is masked in the same cycle as a clearing write.
// Backpressure: none; the hazard unit stalls on BUSY_OUT.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NREGS = NREGS_DEFAULT,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WRITE_ENABLE,
  input  logic [AW-1:0]     WRITE_ADDR,
  input  logic              RSV_ENABLE,
  input  logic [AW-1:0]     RSV_ADDR,
  input  logic [NRD*AW-1:0] OUT_ADDR,
  output logic [NRD-1:0]    BUSY_OUT,
  output logic [AW:0]       PENDING_CNT,
  output logic              RSV_CONFLICT
);
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             set_v;
  logic             clr_v;
  logic             same_addr;
  logic             cnt_inc;
  logic             cnt_dec;
  logic             conflict_nxt;

  assign set_v     = RSV_ENABLE && (RSV_ADDR != AW'(REG_ZERO));
  assign clr_v     = WRITE_ENABLE && (WRITE_ADDR != AW'(REG_ZERO));
  assign same_addr = (RSV_ADDR == WRITE_ADDR);

  // The reserve wins over a same-register write: a newer op owns the destination.
  always_comb begin
    busy_nxt = busy;
    if (clr_v) busy_nxt[WRITE_ADDR] = 1'b0;
    if (set_v) busy_nxt[RSV_ADDR] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign cnt_inc      = set_v && !busy[RSV_ADDR];
  assign cnt_dec      = clr_v && busy[WRITE_ADDR] && !(set_v && same_addr);
  assign conflict_nxt = set_v && busy[RSV_ADDR] && !(clr_v && same_addr);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy         <= '0;
      PENDING_CNT  <= '0;
      RSV_CONFLICT <= 1'b0;
    end else begin
      busy         <= busy_nxt;
      PENDING_CNT  <= PENDING_CNT + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
      RSV_CONFLICT <= conflict_nxt;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_busy
    logic [AW-1:0] ra;
    assign ra          = OUT_ADDR[k*AW +: AW];
    assign BUSY_OUT[k] = busy[ra] && !(WRITE_ENABLE && (WRITE_ADDR == ra));
  end
endmodule

// File: rtl/reg_file_sb.sv
// RV32IM integer register file: NRD combinational read ports with write bypass, one write port, busy scoreboard.
// Latency: reads are zero-cycle; writes land in the array on the edge and bypass in the same cycle.
// Backpressure: none; dependent reads stall externally on BUSY_OUT.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEFAULT,
  parameter  int NREGS = NREGS_DEFAULT,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                WRITE_ENABLE,
  input  logic [AW-1:0]       WRITE_ADDR,
  input  logic [XLEN-1:0]     WRITE_DATA,
  input  logic                RSV_ENABLE,
  input  logic [AW-1:0]       RSV_ADDR,
  input  logic [NRD*AW-1:0]   OUT_ADDR,
  output logic [NRD*XLEN-1:0] DATA_OUT,
  output logic [NRD-1:0]      BUSY_OUT,
  output logic [AW:0]         PENDING_CNT,
  output logic                RSV_CONFLICT
);
  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (WRITE_ENABLE && (WRITE_ADDR != AW'(REG_ZERO))) begin
      mem[WRITE_ADDR] <= WRITE_DATA;
    end
  end

  // x0 check comes first so a write to x0 never leaks through the bypass.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = OUT_ADDR[k*AW +: AW];
    assign DATA_OUT[k*XLEN +: XLEN] =
      (ra == AW'(REG_ZERO))                  ? '0 :
      (WRITE_ENABLE && (WRITE_ADDR == ra))   ? WRITE_DATA :
                                               mem[ra];
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_sb (
    .CLK          (CLK),
    .RESET        (RESET),
    .WRITE_ENABLE (WRITE_ENABLE),
    .WRITE_ADDR   (WRITE_ADDR),
    .RSV_ENABLE   (RSV_ENABLE),
    .RSV_ADDR     (RSV_ADDR),
    .OUT_ADDR     (OUT_ADDR),
    .BUSY_OUT     (BUSY_OUT),
    .PENDING_CNT  (PENDING_CNT),
    .RSV_CONFLICT (RSV_CONFLICT)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reset, bypass, x0, reservation, conflict and reset-discard cases.
// Latency: n/a. Backpressure: n/a.
module tb_reg_file_sb;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        WRITE_ENABLE;
  logic [4:0]  WRITE_ADDR;
  logic [31:0] WRITE_DATA;
  logic        RSV_ENABLE;
  logic [4:0]  RSV_ADDR;
  logic [9:0]  OUT_ADDR;
  logic [63:0] DATA_OUT;
  logic [1:0]  BUSY_OUT;
  logic [5:0]  PENDING_CNT;
  logic        RSV_CONFLICT;

  int n_checks = 0;
  int n_pass   = 0;

  reg_file_sb dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .WRITE_ENABLE (WRITE_ENABLE),
    .WRITE_ADDR   (WRITE_ADDR),
    .WRITE_DATA   (WRITE_DATA),
    .RSV_ENABLE   (RSV_ENABLE),
    .RSV_ADDR     (RSV_ADDR),
    .OUT_ADDR     (OUT_ADDR),
    .DATA_OUT     (DATA_OUT),
    .BUSY_OUT     (BUSY_OUT),
    .PENDING_CNT  (PENDING_CNT),
    .RSV_CONFLICT (RSV_CONFLICT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [4:0] p0, input logic [4:0] p1);
    OUT_ADDR = {p1, p0};
    #1;
  endtask

  task automatic wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    WRITE_ENABLE = en;
    WRITE_ADDR   = a;
    WRITE_DATA   = d;
  endtask

  task automatic rsv(input logic en, input logic [4:0] a);
    RSV_ENABLE = en;
    RSV_ADDR   = a;
  endtask

  initial begin
    RESET = 1'b1;
    wr(1'b0, 5'd0, 32'h0);
    rsv(1'b0, 5'd0);
    OUT_ADDR = '0;
    tick();
    tick();
    RESET = 1'b0;
    #1;

    // Reset state across every address on both ports.
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      check($sformatf("rst_data_%0d", a), DATA_OUT, 64'h0);
      check($sformatf("rst_busy_%0d", a), 64'(BUSY_OUT), 64'h0);
    end
    check("rst_cnt", 64'(PENDING_CNT), 64'h0);
    check("rst_conflict", 64'(RSV_CONFLICT), 64'h0);

    // Write with same-cycle bypass, then from the array.
    wr(1'b1, 5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd6);
    check("bypass_x5", DATA_OUT, {32'h0, 32'hDEADBEEF});
    tick();
    wr(1'b0, 5'd0, 32'h0);
    #1;
    check("array_x5", DATA_OUT, {32'h0, 32'hDEADBEEF});
    wr(1'b1, 5'd5, 32'h11);
    rd(5'd6, 5'd5);
    check("bypass_over_array", DATA_OUT, {32'h11, 32'h0});
    tick();
    wr(1'b0, 5'd0, 32'h0);

    // x0 is immune to writes and reservations.
    wr(1'b1, 5'd0, 32'h1234);
    rsv(1'b1, 5'd0);
    rd(5'd0, 5'd5);
    check("x0_bypass", DATA_OUT, {32'h11, 32'h0});
    tick();
    wr(1'b0, 5'd0, 32'h0);
    rsv(1'b0, 5'd0);
    rd(5'd0, 5'd0);
    check("x0_data", DATA_OUT, 64'h0);
    check("x0_busy", 64'(BUSY_OUT), 64'h0);
    check("x0_cnt", 64'(PENDING_CNT), 64'h0);

    // Two reservations, then a clearing write masked in its own cycle.
    rsv(1'b1, 5'd7);
    tick();
    rsv(1'b1, 5'd9);
    tick();
    rsv(1'b0, 5'd0);
    rd(5'd7, 5'd9);
    check("rsv_busy", 64'(BUSY_OUT), 64'h3);
    check("rsv_cnt2", 64'(PENDING_CNT), 64'h2);
    check("rsv_no_conflict", 64'(RSV_CONFLICT), 64'h0);
    wr(1'b1, 5'd7, 32'h55);
    #1;
    check("clr_mask", 64'(BUSY_OUT), 64'h2);
    check("clr_bypass", DATA_OUT[31:0], 64'h55);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    #1;
    check("clr_cnt1", 64'(PENDING_CNT), 64'h1);
    check("clr_busy", 64'(BUSY_OUT), 64'h2);
    check("clr_data", DATA_OUT[31:0], 64'h55);
    wr(1'b1, 5'd9, 32'h99);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    #1;
    check("clr_cnt0", 64'(PENDING_CNT), 64'h0);

    // Same-edge write+reserve to x3, then a second reserve to a busy x3.
    wr(1'b1, 5'd3, 32'h33);
    rsv(1'b1, 5'd3);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    rd(5'd3, 5'd0);
    check("wr_rsv_busy", 64'(BUSY_OUT), 64'h1);
    check("wr_rsv_data", DATA_OUT, {32'h0, 32'h33});
    check("wr_rsv_cnt", 64'(PENDING_CNT), 64'h1);
    check("wr_rsv_no_conflict", 64'(RSV_CONFLICT), 64'h0);
    tick();
    rsv(1'b0, 5'd0);
    #1;
    check("conflict_pulse", 64'(RSV_CONFLICT), 64'h1);
    check("conflict_busy", 64'(BUSY_OUT), 64'h1);
    check("conflict_cnt", 64'(PENDING_CNT), 64'h1);
    tick();
    check("conflict_drop", 64'(RSV_CONFLICT), 64'h0);

    // Reserve to a busy register with a same-cycle clearing write is not a conflict.
    wr(1'b1, 5'd3, 32'h3A);
    rsv(1'b1, 5'd3);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    rsv(1'b0, 5'd0);
    #1;
    check("clr_rsv_no_conflict", 64'(RSV_CONFLICT), 64'h0);
    check("clr_rsv_cnt", 64'(PENDING_CNT), 64'h1);
    check("clr_rsv_busy", 64'(BUSY_OUT), 64'h1);
    wr(1'b1, 5'd3, 32'h3B);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    #1;
    check("x3_clear_cnt", 64'(PENDING_CNT), 64'h0);

    // Reset discards reservations and wins over a same-cycle write.
    rsv(1'b1, 5'd4);
    tick();
    rsv(1'b0, 5'd0);
    rd(5'd4, 5'd3);
    check("pre_rst_cnt", 64'(PENDING_CNT), 64'h1);
    RESET = 1'b1;
    wr(1'b1, 5'd4, 32'hAA);
    #1;
    check("rst_bypass", DATA_OUT[31:0], 64'hAA);
    tick();
    RESET = 1'b0;
    wr(1'b0, 5'd0, 32'h0);
    #1;
    check("post_rst_data", DATA_OUT, 64'h0);
    check("post_rst_busy", 64'(BUSY_OUT), 64'h0);
    check("post_rst_cnt", 64'(PENDING_CNT), 64'h0);
    wr(1'b1, 5'd4, 32'hBB);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    #1;
    check("late_wr_cnt", 64'(PENDING_CNT), 64'h0);
    check("late_wr_data", DATA_OUT[31:0], 64'hBB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
